// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: state encoding, default sync marker and state decode helpers for the boot loader
package prog_loader_pkg;
  typedef enum logic [3:0] {
    SYNC, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, CHECK, RUN, ERROR
  } state_t;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  function automatic logic rx_state(input state_t s);
    return s inside {SYNC, LEN_HI, LEN_LO, DAT_HI, DAT_LO, CHECK};
  endfunction
  function automatic logic timed_state(input state_t s);
    return rx_state(s) && s != SYNC;
  endfunction
endpackage

// File: rtl/prog_loader_idle_timer.sv
// idle_timer: counts idle cycles and flags the cycle on which the limit is reached
module idle_timer #(
  parameter int unsigned LIMIT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic count,
  input  logic clear,
  output logic expire
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] tmo;
  assign expire = count && !clear && tmo == W'(LIMIT - 1);
  // idle counter, cleared by reset, a transfer or leaving the timed states
  always_ff @(posedge clk)
    tmo <= (!reset || clear) ? '0 : count ? tmo + 1'b1 : tmo;
endmodule

// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream boot loader writing program memory and gating CPU reset
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int          DATA_W    = 16,
  parameter logic [7:0]  SYNC_BYTE = SYNC_DEFAULT,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);
  localparam int CW = ADDR_W + 1;
  localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;
  state_t state, nxt;
  logic [7:0] len_hi, hi, chk;
  logic [CW-1:0] count;
  logic [ADDR_W-1:0] addr;
  logic [15:0] len;
  logic xfer, idle, expire;
  assign xfer = byte_valid && byte_ready;
  assign len = {len_hi, byte_in};
  assign idle = timed_state(state) && !xfer;
  idle_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .count  (idle),
    .clear  (!idle),
    .expire (expire)
  );
  // next-state logic; an expired idle timer overrides every other transition
  always_comb begin
    nxt = state;
    case (state)
      SYNC:       if (xfer && byte_in == SYNC_BYTE) nxt = LEN_HI;
      LEN_HI:     if (xfer) nxt = LEN_LO;
      LEN_LO:     if (xfer) nxt = (len == 16'd0) ? CHECK : ({16'd0, len} > DEPTH) ? ERROR : DAT_HI;
      DAT_HI:     if (xfer) nxt = DAT_LO;
      DAT_LO:     if (xfer) nxt = WRITE;
      WRITE:      nxt = (count == CW'(1)) ? CHECK : DAT_HI;
      CHECK:      if (xfer) nxt = (byte_in == chk) ? RUN : ERROR;
      RUN, ERROR: if (reload) nxt = SYNC;
      default:    nxt = SYNC;
    endcase
    if (expire) nxt = ERROR;
  end
  // state register and status outputs, registered from the next state
  always_ff @(posedge clk) begin
    state      <= !reset ? SYNC : nxt;
    byte_ready <= !reset || rx_state(nxt);
    cpu_reset  <= !reset || nxt != RUN;
    done       <= reset && nxt == RUN;
    error      <= reset && nxt == ERROR;
  end
  // frame datapath: length, checksum, byte assembly and the memory write port
  always_ff @(posedge clk)
    if (!reset) begin
      len_hi    <= '0;
      hi        <= '0;
      chk       <= '0;
      count     <= '0;
      addr      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= state == DAT_LO && xfer;
      if (state == SYNC && xfer && byte_in == SYNC_BYTE) chk <= '0;
      if (state == LEN_HI && xfer) len_hi <= byte_in;
      if (state == LEN_LO && xfer) begin
        count <= CW'(len);
        addr  <= '0;
        chk   <= '0;
      end
      if (state == DAT_HI && xfer) begin
        hi  <= byte_in;
        chk <= chk ^ byte_in;
      end
      if (state == DAT_LO && xfer) begin
        chk       <= chk ^ byte_in;
        mem_addr  <= addr;
        mem_wdata <= DATA_W'({hi, byte_in});
      end
      if (state == WRITE) begin
        addr  <= addr + 1'b1;
        count <= count - 1'b1;
      end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed frame sequences with hand-computed writes and status
module tb_prog_loader;
  logic clk = 1'b0, reset = 1'b0, byte_valid = 1'b0, reload = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic byte_ready, mem_we, cpu_reset, done, error;
  logic [1:0] mem_addr;
  logic [15:0] mem_wdata;
  int n_cmp = 0, n_err = 0, wtot = 0, base = 0;
  logic [1:0] wa [64];
  logic [15:0] wd [64];
  logic [7:0] q [$];

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(2), .TIMEOUT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .reload     (reload),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always @(negedge clk)
    if (mem_we === 1'b1) begin
      wa[wtot % 64] = mem_addr;
      wd[wtot % 64] = mem_wdata;
      wtot++;
    end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    byte_in = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", byte_ready, 1);
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic send_q();
    foreach (q[i]) send(q[i]);
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic check_wr(input int k, input logic [1:0] a, input logic [15:0] d);
    check("wr_addr", wa[(base + k) % 64], a);
    check("wr_data", wd[(base + k) % 64], d);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_ready", byte_ready, 1);
    @(negedge clk);
    reset = 1'b1;

    base = wtot;
    q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    send_q();
    check("nom_writes", wtot - base, 2);
    check_wr(0, 2'd0, 16'h1234);
    check_wr(1, 2'd1, 16'hABCD);
    check("nom_done", done, 1);
    check("nom_cpu_reset", cpu_reset, 0);
    check("nom_error", error, 0);
    check("nom_ready", byte_ready, 0);
    pulse_reload();
    check("reload_cpu_reset", cpu_reset, 1);
    check("reload_done", done, 0);
    check("reload_ready", byte_ready, 1);

    base = wtot;
    q = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'hFF, 8'h00};
    send_q();
    check("bad_writes", wtot - base, 1);
    check_wr(0, 2'd0, 16'h00FF);
    check("bad_error", error, 1);
    check("bad_cpu_reset", cpu_reset, 1);
    check("bad_done", done, 0);
    pulse_reload();
    check("bad_reload_error", error, 0);
    base = wtot;
    q = '{8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h51};
    send_q();
    check_wr(0, 2'd0, 16'hBEEF);
    check("good_done", done, 1);
    check("good_cpu_reset", cpu_reset, 0);

    pulse_reload();
    base = wtot;
    q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00};
    send_q();
    check("garb_writes", wtot - base, 0);
    check("garb_done", done, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      byte_in = 8'hA5;
      byte_valid = 1'b1;
      check("hold_ready", byte_ready, 0);
      check("hold_done", done, 1);
    end
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    byte_valid = 1'b0;
    check("rl_vs_byte_done", done, 0);
    check("rl_vs_byte_cpu_reset", cpu_reset, 1);
    check("rl_vs_byte_ready", byte_ready, 1);
    check("hold_writes", wtot - base, 0);

    base = wtot;
    q = '{8'hA5, 8'h00, 8'h05};
    send_q();
    check("ovf_error", error, 1);
    check("ovf_ready", byte_ready, 0);
    check("ovf_writes", wtot - base, 0);
    pulse_reload();
    base = wtot;
    q = '{8'hA5, 8'h00, 8'h04, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04};
    send_q();
    @(posedge clk);
    #1;
    check("len4_writes", wtot - base, 4);
    check("len4_check_ready", byte_ready, 1);
    check("len4_check_done", done, 0);
    check_wr(0, 2'd0, 16'h0001);
    check_wr(3, 2'd3, 16'h0004);
    send(8'h04);
    check("len4_done", done, 1);
    check("len4_writes_after", wtot - base, 4);

    pulse_reload();
    base = wtot;
    q = '{8'hA5, 8'h00, 8'h01, 8'h12};
    send_q();
    repeat (7) @(posedge clk);
    #1;
    check("tmo_before", error, 0);
    @(posedge clk);
    #1;
    check("tmo_error", error, 1);
    check("tmo_cpu_reset", cpu_reset, 1);
    check("tmo_writes", wtot - base, 0);

    pulse_reload();
    q = '{8'hA5, 8'h00, 8'h01, 8'h77};
    send_q();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("mid_cpu_reset", cpu_reset, 1);
    check("mid_done", done, 0);
    check("mid_error", error, 0);
    check("mid_mem_we", mem_we, 0);
    check("mid_mem_addr", mem_addr, 0);
    check("mid_mem_wdata", mem_wdata, 0);
    check("mid_ready", byte_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    base = wtot;
    q = '{8'hA5, 8'h00, 8'h01, 8'h56, 8'h78, 8'h2E};
    send_q();
    check("fresh_writes", wtot - base, 1);
    check_wr(0, 2'd0, 16'h5678);
    check("fresh_done", done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
